// File: rtl/dma_multichannel_timing_ctrl.sv
// 8237-style DMA timing/control FSM: per-channel address/count, fixed priority, single/block modes.
// Optional feature: define DMA_AUTOINIT_EN for per-channel base registers and autoinit reload.
module dma_multichannel_timing_ctrl #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              READY,
    input  logic              EOP_N_IN,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [4:0]        cfg_mode,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              AEN,
    output logic              ADSTB,
    output logic [ADDR_W-1:0] ADDR_OUT,
    output logic              MEMR_N,
    output logic              MEMW_N,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic              EOP_N_OUT,
    output logic [NUM_CH-1:0] TC,
    output logic              BUSY
);

    typedef enum logic [2:0] {StSi, StS0, StS1, StS2, StS3, StS4} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] cur_addr_q [NUM_CH];
    logic [CNT_W-1:0]  cur_cnt_q  [NUM_CH];
    logic [4:0]        mode_q     [NUM_CH];
    logic [NUM_CH-1:0] enable_q;
    logic [NUM_CH-1:0] tc_q;
    logic [CH_W-1:0]   ch_q;
    logic              eop_seen_q;
    logic              hlda_lost_q;
`ifdef DMA_AUTOINIT_EN
    logic [ADDR_W-1:0] base_addr_q [NUM_CH];
    logic [CNT_W-1:0]  base_cnt_q  [NUM_CH];
`endif

    logic [NUM_CH-1:0] eligible;
    logic              any_elig;
    logic [CH_W-1:0]   win_ch;
    logic [ADDR_W-1:0] act_addr;
    logic [CNT_W-1:0]  act_cnt;
    logic [4:0]        act_mode;
    logic              terminal;
    logic              ext_eop;
    logic              hlda_gone;
    logic              cfg_ok;

    assign eligible  = DREQ & enable_q;
    assign any_elig  = |eligible;
    assign act_addr  = cur_addr_q[ch_q];
    assign act_cnt   = cur_cnt_q[ch_q];
    assign act_mode  = mode_q[ch_q];
    assign terminal  = (state_q == StS4) && (act_cnt == '0);
    assign ext_eop   = eop_seen_q | ~EOP_N_IN;
    assign hlda_gone = hlda_lost_q | ~HLDA;
    assign cfg_ok    = cfg_we && (state_q == StSi) && !HLDA;

`ifndef DMA_AUTOINIT_EN
    logic unused_autoinit;
    assign unused_autoinit = act_mode[4];
`endif

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) win_ch = CH_W'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= StSi;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSi: if (!cfg_ok && any_elig) state_d = StS0;
            StS0: begin
                if (!any_elig || !EOP_N_IN) state_d = StSi;
                else if (HLDA)              state_d = StS1;
            end
            StS1: state_d = StS2;
            StS2: state_d = StS3;
            StS3: if (READY) state_d = StS4;
            StS4: begin
                if (terminal || ext_eop || hlda_gone) state_d = StSi;
                else if (act_mode[2])                 state_d = StS1;
                else                                  state_d = StSi;
            end
            default: state_d = StSi;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_addr_q[i]  <= '0;
                cur_cnt_q[i]   <= '0;
                mode_q[i]      <= '0;
`ifdef DMA_AUTOINIT_EN
                base_addr_q[i] <= '0;
                base_cnt_q[i]  <= '0;
`endif
            end
            enable_q    <= '0;
            tc_q        <= '0;
            ch_q        <= '0;
            eop_seen_q  <= 1'b0;
            hlda_lost_q <= 1'b0;
        end else begin
            if (cfg_ok && (int'(cfg_ch) < int'(NUM_CH))) begin
                cur_addr_q[cfg_ch]  <= cfg_addr;
                cur_cnt_q[cfg_ch]   <= cfg_count;
                mode_q[cfg_ch]      <= cfg_mode;
                enable_q[cfg_ch]    <= 1'b1;
                tc_q[cfg_ch]        <= 1'b0;
`ifdef DMA_AUTOINIT_EN
                base_addr_q[cfg_ch] <= cfg_addr;
                base_cnt_q[cfg_ch]  <= cfg_count;
`endif
            end
            if (state_q == StS0 && state_d == StS1) ch_q <= win_ch;
            // Abort conditions are remembered for the word in flight only.
            if (state_q == StS1 || state_q == StS2 || state_q == StS3) begin
                eop_seen_q  <= eop_seen_q | ~EOP_N_IN;
                hlda_lost_q <= hlda_lost_q | ~HLDA;
            end else begin
                eop_seen_q  <= 1'b0;
                hlda_lost_q <= 1'b0;
            end
            if (state_q == StS4) begin
                cur_addr_q[ch_q] <= act_mode[3] ? act_addr - ADDR_W'(1) : act_addr + ADDR_W'(1);
                cur_cnt_q[ch_q]  <= act_cnt - CNT_W'(1);
                if (terminal || ext_eop) begin
                    tc_q[ch_q]     <= 1'b1;
                    enable_q[ch_q] <= 1'b0;
                end
`ifdef DMA_AUTOINIT_EN
                if (terminal && act_mode[4]) begin
                    cur_addr_q[ch_q] <= base_addr_q[ch_q];
                    cur_cnt_q[ch_q]  <= base_cnt_q[ch_q];
                    enable_q[ch_q]   <= 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        HRQ       = 1'b0;
        DACK      = '0;
        AEN       = 1'b0;
        ADSTB     = 1'b0;
        ADDR_OUT  = '0;
        MEMR_N    = 1'b1;
        MEMW_N    = 1'b1;
        IOR_N     = 1'b1;
        IOW_N     = 1'b1;
        EOP_N_OUT = 1'b1;
        TC        = tc_q;
        BUSY      = (state_q != StSi);
        if (state_q != StSi) HRQ = 1'b1;
        if (state_q inside {StS1, StS2, StS3, StS4}) begin
            AEN      = 1'b1;
            ADDR_OUT = act_addr;
            for (int i = 0; i < NUM_CH; i++) DACK[i] = (ch_q == CH_W'(i));
        end
        if (state_q == StS1) ADSTB = 1'b1;
        if (state_q == StS2 || state_q == StS3) begin
            if (act_mode[1:0] == 2'b01) begin
                IOR_N  = 1'b0;
                MEMW_N = 1'b0;
            end else if (act_mode[1:0] == 2'b10) begin
                MEMR_N = 1'b0;
                IOW_N  = 1'b0;
            end
        end
        if (terminal) EOP_N_OUT = 1'b0;
    end

endmodule

// File: tb/tb_dma_multichannel_timing_ctrl.sv
// Directed self-checking bench for dma_multichannel_timing_ctrl (NUM_CH=4, 16-bit counters).
module tb_dma_multichannel_timing_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  DREQ;
    logic        HLDA, READY, EOP_N_IN;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_addr, cfg_count;
    logic [4:0]  cfg_mode;
    logic        HRQ, AEN, ADSTB;
    logic [3:0]  DACK, TC;
    logic [15:0] ADDR_OUT;
    logic        MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT, BUSY;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] StrbNone  = 4'b1111;  // {MEMR_N, MEMW_N, IOR_N, IOW_N}
    localparam logic [3:0] StrbWrite = 4'b1001;
    localparam logic [3:0] StrbRead  = 4'b0110;

    dma_multichannel_timing_ctrl #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .READY(READY), .EOP_N_IN(EOP_N_IN),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .cfg_mode(cfg_mode), .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB), .ADDR_OUT(ADDR_OUT),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N_OUT(EOP_N_OUT),
        .TC(TC), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {MEMR_N, MEMW_N, IOR_N, IOW_N};
    endfunction

    task automatic program_ch(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c,
                              input logic [4:0] m);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_count = c; cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    // Called with the FSM in S1; leaves it in S4.
    task automatic do_word(input string tag, input logic [15:0] a, input logic [3:0] dack,
                           input logic [3:0] strb, input logic eop);
        check({tag, " s1 adstb/aen"}, {30'd0, ADSTB, AEN}, 32'h3);
        check({tag, " s1 addr"}, ADDR_OUT, a);
        check({tag, " s1 dack"}, DACK, dack);
        tick();
        check({tag, " s2 strb"}, strobes(), strb);
        check({tag, " s2 aen/adstb"}, {30'd0, AEN, ADSTB}, 32'h2);
        tick();
        check({tag, " s3 strb"}, strobes(), strb);
        tick();
        check({tag, " s4 strb"}, strobes(), StrbNone);
        check({tag, " s4 eop"}, EOP_N_OUT, eop);
        check({tag, " s4 addr"}, ADDR_OUT, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " hrq/aen/adstb/busy"}, {28'd0, HRQ, AEN, ADSTB, BUSY}, 32'h0);
        check({tag, " dack"}, DACK, 4'h0);
        check({tag, " tc"}, TC, 4'h0);
        check({tag, " addr"}, ADDR_OUT, 16'h0);
        check({tag, " strobes"}, {strobes(), EOP_N_OUT}, 5'h1f);
    endtask

    initial begin
        RESET = 1'b1; DREQ = '0; HLDA = 1'b0; READY = 1'b1; EOP_N_IN = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_count = '0; cfg_mode = '0;
        tick(); tick();
        check_reset_outputs("reset");
        RESET = 1'b0;
        tick();

        // 1: ch0 single write, 3 words
        program_ch(2'd0, 16'h1000, 16'd2, 5'b00001);
        DREQ = 4'b0001;
        tick();
        check("t1 hrq", HRQ, 1'b1);
        check("t1 s0 dack", DACK, 4'h0);
        HLDA = 1'b1;
        tick();
        do_word("t1w0", 16'h1000, 4'b0001, StrbWrite, 1'b1);
        tick();
        check("t1 released", {30'd0, HRQ, BUSY}, 32'h0);
        tick(); tick();
        do_word("t1w1", 16'h1001, 4'b0001, StrbWrite, 1'b1);
        tick(); tick(); tick();
        do_word("t1w2", 16'h1002, 4'b0001, StrbWrite, 1'b0);
        tick();
        check("t1 tc", TC, 4'b0001);
        check("t1 hrq drop", HRQ, 1'b0);
        tick();
        check("t1 stays idle", BUSY, 1'b0);
        DREQ = '0; HLDA = 1'b0;
        tick();

        // 2: ch1 and ch3 both requesting
        program_ch(2'd1, 16'h2000, 16'd0, 5'b00010);
        program_ch(2'd3, 16'h3000, 16'd0, 5'b00000);
        DREQ = 4'b1010; HLDA = 1'b1;
        tick(); tick();
        do_word("t2ch1", 16'h2000, 4'b0010, StrbRead, 1'b0);
        tick();
        check("t2 tc1", TC, 4'b0011);
        tick(); tick();
        do_word("t2ch3", 16'h3000, 4'b1000, StrbNone, 1'b0);
        tick();
        check("t2 tc3", TC, 4'b1011);
        DREQ = '0; HLDA = 1'b0;
        tick();

        // 3: block mode with address wrap
        program_ch(2'd2, 16'hFFFF, 16'd1, 5'b00101);
        DREQ = 4'b0100; HLDA = 1'b1;
        tick(); tick();
        DREQ = '0;
        do_word("t3w0", 16'hFFFF, 4'b0100, StrbWrite, 1'b1);
        tick();
        do_word("t3w1", 16'h0000, 4'b0100, StrbWrite, 1'b0);
        tick();
        check("t3 end", {28'd0, HRQ, BUSY, 2'b00}, 32'h0);
        check("t3 tc", TC, 4'b1111);
        HLDA = 1'b0;
        tick();

        // 4: READY wait states
        program_ch(2'd0, 16'h4000, 16'd1, 5'b00001);
        check("t4 tc clr", TC, 4'b1110);
        DREQ = 4'b0001; HLDA = 1'b1;
        tick(); tick();
        check("t4 s1 addr", ADDR_OUT, 16'h4000);
        tick();
        READY = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4 wait%0d strb", i), strobes(), StrbWrite);
            check($sformatf("t4 wait%0d addr", i), ADDR_OUT, 16'h4000);
            tick();
        end
        READY = 1'b1;
        check("t4 last s3 strb", strobes(), StrbWrite);
        tick();
        check("t4 s4 strb", strobes(), StrbNone);
        check("t4 s4 eop", EOP_N_OUT, 1'b1);
        tick(); tick(); tick();
        do_word("t4w1", 16'h4001, 4'b0001, StrbWrite, 1'b0);
        tick();
        check("t4 tc", TC, 4'b1111);
        DREQ = '0; HLDA = 1'b0;
        tick();

        // 5: external EOP in S2, then reset in S3
        program_ch(2'd1, 16'h5000, 16'd5, 5'b00010);
        DREQ = 4'b0010; HLDA = 1'b1;
        tick(); tick();
        check("t5 s1 dack", DACK, 4'b0010);
        tick();
        EOP_N_IN = 1'b0;
        tick();
        EOP_N_IN = 1'b1;
        check("t5 s3 strb", strobes(), StrbRead);
        tick();
        check("t5 s4 no eop pulse", EOP_N_OUT, 1'b1);
        tick();
        check("t5 idle", BUSY, 1'b0);
        check("t5 tc", TC, 4'b1111);
        tick();
        check("t5 disabled", HRQ, 1'b0);
        DREQ = '0; HLDA = 1'b0;
        tick();
        program_ch(2'd3, 16'h6000, 16'd5, 5'b00001);
        DREQ = 4'b1000; HLDA = 1'b1;
        tick(); tick(); tick(); tick();
        check("t5 in s3", strobes(), StrbWrite);
        RESET = 1'b1;
        tick();
        check_reset_outputs("t5 mid reset");
        RESET = 1'b0;
        tick();
        check("t5 ch disabled after reset", BUSY, 1'b0);
        DREQ = '0; HLDA = 1'b0;
        tick();

        // 6: autoinit
        program_ch(2'd0, 16'h0020, 16'd0, 5'b10001);
        DREQ = 4'b0001; HLDA = 1'b1;
        tick(); tick();
        do_word("t6w0", 16'h0020, 4'b0001, StrbWrite, 1'b0);
        tick();
        check("t6 tc", TC, 4'b0001);
        tick();
`ifdef DMA_AUTOINIT_EN
        check("t6 rerequest", HRQ, 1'b1);
        tick();
        check("t6 reload addr", ADDR_OUT, 16'h0020);
        check("t6 reload dack", DACK, 4'b0001);
`else
        check("t6 no rerequest", HRQ, 1'b0);
        tick();
        check("t6 stays idle", BUSY, 1'b0);
`endif
        DREQ = '0; HLDA = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
